lsu_apb_master: RTL and testbench

Initiator-side bridge between the pipeline's load/store unit and the APB peripheral bus. It accepts one byte/half/word load or store request at a time, encoded with the same 4-bit `bmask` operation code the data memory uses. It drives an APB3/APB4 SETUP/ACCESS transfer with correct byte lanes and strobes, waits on `pready`, and returns sign/zero-extended load data plus a done/error pulse. It sits in the MEM stage, beside the data memory, for addresses decoded as peripheral space.

---
 rtl/lsu_apb_master_if.sv | 33 +++
 rtl/lsu_apb_master.sv | 205 ++++++++++++++++++++
 tb/tb_lsu_apb_master.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_apb_master_if.sv
// LSU request and APB initiator signal bundle for lsu_apb_master.
interface lsu_apb_master_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_bmask;
    logic        i_wren;
    logic [31:0] o_rdata;
    logic        o_done;
    logic        o_err;
    logic        o_busy;
    logic [31:0] o_paddr;
    logic        o_psel;
    logic        o_penable;
    logic        o_pwrite;
    logic [31:0] o_pwdata;
    logic [3:0]  o_pstrb;
    logic [31:0] i_prdata;
    logic        i_pready;
    logic        i_pslverr;

    modport master (
        input  i_req, i_addr, i_wdata, i_bmask, i_wren, i_prdata, i_pready, i_pslverr,
        output o_rdata, o_done, o_err, o_busy, o_paddr, o_psel, o_penable, o_pwrite,
               o_pwdata, o_pstrb
    );

    modport slave (
        output i_req, i_addr, i_wdata, i_bmask, i_wren, i_prdata, i_pready, i_pslverr,
        input  o_rdata, o_done, o_err, o_busy, o_paddr, o_psel, o_penable, o_pwrite,
               o_pwdata, o_pstrb
    );
endinterface

// File: rtl/lsu_apb_master.sv
// LSU-to-APB initiator bridge: one byte/half/word load or store per transfer.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module lsu_apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    lsu_apb_master_if.master  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;

    logic        illegal_c, misalign_c, reject_c, timeout_c;
    logic [31:0] st_data_c;
    logic [3:0]  st_strb_c;
    logic [31:0] ld_shift_c, ld_data_c;
    logic [15:0] ld_half_c;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_c = 1'b0;
`endif

    // Request decode: legality, alignment and store lane placement
    always_comb begin
        illegal_c  = 1'b0;
        misalign_c = 1'b0;
        st_data_c  = 32'h0;
        st_strb_c  = 4'b0000;
        case (bus.i_bmask)
            4'b0000, 4'b0001: ;
            4'b0010, 4'b0011: misalign_c = bus.i_addr[0];
            4'b0100:          misalign_c = (bus.i_addr[1:0] != 2'b00);
            4'b1000: begin
                st_data_c = {4{bus.i_wdata[7:0]}};
                st_strb_c = 4'b0001 << bus.i_addr[1:0];
            end
            4'b1001: begin
                misalign_c = bus.i_addr[0];
                st_data_c  = {2{bus.i_wdata[15:0]}};
                st_strb_c  = bus.i_addr[1] ? 4'b1100 : 4'b0011;
            end
            4'b1010: begin
                misalign_c = (bus.i_addr[1:0] != 2'b00);
                st_data_c  = bus.i_wdata;
                st_strb_c  = 4'b1111;
            end
            default: illegal_c = 1'b1;
        endcase
        reject_c = illegal_c | misalign_c | (bus.i_wren != bus.i_bmask[3]);
    end

    // Load lane extraction and extension from the latched op/offset
    always_comb begin
        ld_shift_c = bus.i_prdata >> {off_q, 3'b000};
        ld_half_c  = off_q[1] ? bus.i_prdata[31:16] : bus.i_prdata[15:0];
        case (op_q)
            4'b0000: ld_data_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
            4'b0001: ld_data_c = {24'h0, ld_shift_c[7:0]};
            4'b0010: ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
            4'b0011: ld_data_c = {16'h0, ld_half_c};
            default: ld_data_c = bus.i_prdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        op_d      = op_q;
        off_d     = off_q;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.i_req) begin
                    if (reject_c) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d   = S_SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = {bus.i_addr[31:2], 2'b00};
                        pwrite_d  = bus.i_wren;
                        pwdata_d  = st_data_c;
                        pstrb_d   = st_strb_c;
                        op_d      = bus.i_bmask;
                        off_d     = bus.i_addr[1:0];
                    end
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            S_ACCESS: begin
                if (bus.i_pready) begin
                    state_d   = S_RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = bus.i_pslverr;
                    rdata_d   = (bus.i_pslverr || pwrite_q) ? 32'h0 : ld_data_c;
                end else if (timeout_c) begin
                    state_d   = S_RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = 32'h0;
                end else begin
`ifdef APB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            paddr_q   <= 32'h0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= 32'h0;
            pstrb_q   <= 4'b0000;
            rdata_q   <= 32'h0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            op_q      <= 4'b0000;
            off_q     <= 2'b00;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            op_q      <= op_d;
            off_q     <= off_d;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.o_paddr   = paddr_q;
    assign bus.o_psel    = psel_q;
    assign bus.o_penable = penable_q;
    assign bus.o_pwrite  = pwrite_q;
    assign bus.o_pwdata  = pwdata_q;
    assign bus.o_pstrb   = pstrb_q;
    assign bus.o_rdata   = rdata_q;
    assign bus.o_done    = done_q;
    assign bus.o_err     = err_q;
    assign bus.o_busy    = busy_q;
endmodule

// File: tb/tb_lsu_apb_master.sv
// Self-checking bench for lsu_apb_master: directed test-plan cases plus random
// transactions against a spec-level reference model.
module tb_lsu_apb_master;
`ifdef APB_TIMEOUT_EN
    localparam int unsigned TO_CFG = 4;
    localparam int          TO_LIM = 4;
`else
    localparam int unsigned TO_CFG = 255;
    localparam int          TO_LIM = 32'h7FFF_FFFF;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    lsu_apb_master_if bus ();

    lsu_apb_master #(.TIMEOUT_CYCLES(TO_CFG)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Access size in bytes from the op code; 0 means illegal
    function automatic int m_size(input logic [3:0] bm);
        case (bm)
            4'b0000, 4'b0001, 4'b1000: return 1;
            4'b0010, 4'b0011, 4'b1001: return 2;
            4'b0100, 4'b1010:          return 4;
            default:                   return 0;
        endcase
    endfunction

    function automatic bit m_reject(input logic [3:0] bm, input logic wr, input logic [31:0] ad);
        int sz = m_size(bm);
        if (sz == 0) return 1'b1;
        if (wr != bm[3]) return 1'b1;
        return (ad % sz) != 0;
    endfunction

    function automatic logic [31:0] m_pwdata(input logic [3:0] bm, input logic [31:0] wd);
        case (m_size(bm))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] m_pstrb(input logic [3:0] bm, input logic [31:0] ad);
        int sz = m_size(bm);
        int o = int'(ad % 4);
        if (!bm[3]) return 4'b0000;
        if (sz == 4) return 4'b1111;
        return 4'(((1 << sz) - 1) << o);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [3:0] bm, input logic [31:0] ad,
                                            input logic [31:0] prd);
        int sz = m_size(bm);
        logic [31:0] mask, v;
        if (sz == 4) return prd;
        mask = (sz == 1) ? 32'hFF : 32'hFFFF;
        v = (prd >> (8 * (ad % sz == 0 ? int'(ad % 4) : 0))) & mask;
        if ((bm == 4'b0000 || bm == 4'b0010) && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    // One transaction starting in IDLE; ends one cycle after o_done, back in IDLE
    task automatic run_txn(input logic [3:0] bm, input logic wr, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [31:0] prd,
                           input int waits, input logic slv);
        bit          rej = m_reject(bm, wr, ad);
        bit          tmo = !rej && (waits >= TO_LIM);
        int          done_cyc = rej ? 1 : (tmo ? 2 + TO_LIM : 3 + waits);
        logic        exp_err = rej || tmo || slv;
        logic [31:0] exp_rd = (exp_err || wr) ? 32'h0 : m_rdata(bm, ad, prd);
        bus.i_req = 1'b1; bus.i_bmask = bm; bus.i_wren = wr;
        bus.i_addr = ad; bus.i_wdata = wd; bus.i_prdata = prd;
        bus.i_pready = 1'b0; bus.i_pslverr = 1'b0;
        for (int c = 1; c <= done_cyc; c++) begin
            @(posedge clk); #1;
            chk("busy", 32'(bus.o_busy), 32'd1);
            if (c == done_cyc) begin
                chk("done", 32'(bus.o_done), 32'd1);
                chk("err", 32'(bus.o_err), 32'(exp_err));
                chk("rdata", bus.o_rdata, exp_rd);
                chk("psel_end", 32'(bus.o_psel), 32'd0);
                chk("penable_end", 32'(bus.o_penable), 32'd0);
            end else begin
                chk("done_early", 32'(bus.o_done), 32'd0);
                chk("psel", 32'(bus.o_psel), 32'd1);
                chk("penable", 32'(bus.o_penable), (c >= 2) ? 32'd1 : 32'd0);
                chk("paddr", bus.o_paddr, ad & 32'hFFFF_FFFC);
                chk("pwrite", 32'(bus.o_pwrite), 32'(wr));
                chk("pstrb", 32'(bus.o_pstrb), 32'(m_pstrb(bm, ad)));
                if (wr) chk("pwdata", bus.o_pwdata, m_pwdata(bm, wd));
            end
            if (!rej && !tmo && c == 2 + waits) begin
                bus.i_pready = 1'b1; bus.i_pslverr = slv;
            end
        end
        bus.i_req = 1'b0; bus.i_pready = 1'b0; bus.i_pslverr = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", 32'(bus.o_done), 32'd0);
        chk("idle_busy", 32'(bus.o_busy), 32'd0);
        chk("idle_psel", 32'(bus.o_psel), 32'd0);
    endtask

    initial begin
        logic [3:0] ops [10];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                4'b1000, 4'b1001, 4'b1010, 4'b0111, 4'b1111};
        bus.i_req = 1'b0; bus.i_addr = 32'h0; bus.i_wdata = 32'h0; bus.i_bmask = 4'b0000;
        bus.i_wren = 1'b0; bus.i_prdata = 32'h0; bus.i_pready = 1'b0; bus.i_pslverr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel", 32'(bus.o_psel), 32'd0);
        chk("rst_penable", 32'(bus.o_penable), 32'd0);
        chk("rst_pwrite", 32'(bus.o_pwrite), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_paddr", bus.o_paddr, 32'h0);
        chk("rst_pwdata", bus.o_pwdata, 32'h0);
        chk("rst_rdata", bus.o_rdata, 32'h0);
        chk("rst_pstrb", 32'(bus.o_pstrb), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stores and loads from the directed plan
        run_txn(4'b1010, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        run_txn(4'b1000, 1'b1, 32'h1000_0003, 32'h0000_00A5, 32'h0, 0, 1'b0);
        run_txn(4'b1001, 1'b1, 32'h1000_0002, 32'h0000_1234, 32'h0, 0, 1'b0);
        run_txn(4'b0000, 1'b0, 32'h1000_0001, 32'h0, 32'h0080_F000, 0, 1'b0);
        run_txn(4'b0001, 1'b0, 32'h1000_0001, 32'h0, 32'h0080_F000, 0, 1'b0);
        run_txn(4'b0010, 1'b0, 32'h1000_0002, 32'h0, 32'h0080_F000, 0, 1'b0);
        run_txn(4'b0100, 1'b0, 32'h1000_0000, 32'h0, 32'h0080_F000, 0, 1'b0);
        // Wait states, slave error, rejected requests
        run_txn(4'b0100, 1'b0, 32'h1000_0000, 32'h0, 32'h1357_9BDF, 5, 1'b0);
        run_txn(4'b0100, 1'b0, 32'h1000_0000, 32'h0, 32'h1357_9BDF, 5, 1'b1);
        run_txn(4'b0100, 1'b0, 32'h1000_0002, 32'h0, 32'h0, 0, 1'b0);
        run_txn(4'b0111, 1'b0, 32'h1000_0000, 32'h0, 32'h0, 0, 1'b0);
        run_txn(4'b1010, 1'b0, 32'h1000_0000, 32'h0, 32'h0, 0, 1'b0);
`ifdef APB_TIMEOUT_EN
        run_txn(4'b0100, 1'b0, 32'h1000_0004, 32'h0, 32'h0, TO_LIM, 1'b0);
        run_txn(4'b0100, 1'b0, 32'h1000_0004, 32'h0, 32'hCAFE_0001, TO_LIM - 1, 1'b0);
`else
        run_txn(4'b0100, 1'b0, 32'h1000_0004, 32'h0, 32'hCAFE_0001, 20, 1'b0);
`endif

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            logic [3:0] bm = ops[$urandom_range(0, 9)];
            logic       wr = bm[3] ^ ($urandom_range(0, 7) == 0);
            run_txn(bm, wr, 32'h1000_0000 | 32'($urandom_range(0, 15)), $urandom, $urandom,
                    int'($urandom_range(0, 6)), 1'($urandom_range(0, 4) == 0));
        end

        // Reset during ACCESS aborts the store
        bus.i_req = 1'b1; bus.i_bmask = 4'b1010; bus.i_wren = 1'b1;
        bus.i_addr = 32'h1000_000C; bus.i_wdata = 32'hA5A5_0F0F;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_penable", 32'(bus.o_penable), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_psel", 32'(bus.o_psel), 32'd0);
        chk("mid_rst_penable", 32'(bus.o_penable), 32'd0);
        chk("mid_rst_pwrite", 32'(bus.o_pwrite), 32'd0);
        chk("mid_rst_paddr", bus.o_paddr, 32'h0);
        chk("mid_rst_pwdata", bus.o_pwdata, 32'h0);
        chk("mid_rst_pstrb", 32'(bus.o_pstrb), 32'h0);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("mid_rst_done", 32'(bus.o_done), 32'd0);
        bus.i_req = 1'b0; bus.i_pready = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("post_rst_done", 32'(bus.o_done), 32'd0);
        end
        bus.i_pready = 1'b0;
        run_txn(4'b0011, 1'b0, 32'h1000_0002, 32'h0, 32'h8001_7FFF, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
